// File: rtl/alu_result_capture.sv
// Registered output stage behind the combinational ALU: 2-entry skid buffer between the ALU
// issuer and its consumer, plus sticky flags, a zero-flag sanity check and saturating counters.
module alu_result_capture #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    input  logic             sticky_clear,
    output logic             sticky_carry,
    output logic             sticky_ovf,
    output logic             flag_err,
    output logic [CNT_W-1:0] result_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e     state_q;
    entry_t     in_entry;
    entry_t     main_q;
    entry_t     skid_q;
    logic       accept;
    logic       fire;

    logic             sticky_carry_q, sticky_carry_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             flag_err_q, flag_err_d;
    logic [CNT_W-1:0] result_count_q, result_count_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic [CNT_W-1:0] result_base, ovf_base;

    // Ready depends only on state (and reset), so out_ready never reaches the issuer.
    assign in_ready  = !rst && (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.opcode = in_opcode;
        in_entry.result = in_result;
        in_entry.carry  = in_carry;
        in_entry.zero   = in_zero;
        in_entry.ovf    = in_ovf;
    end

    // Clear is applied first so a same-cycle accept lands on a fresh status.
    always_comb begin
        result_base    = sticky_clear ? '0 : result_count_q;
        ovf_base       = sticky_clear ? '0 : ovf_count_q;
        sticky_carry_d = !sticky_clear && sticky_carry_q;
        sticky_ovf_d   = !sticky_clear && sticky_ovf_q;
        flag_err_d     = !sticky_clear && flag_err_q;
        result_count_d = result_base;
        ovf_count_d    = ovf_base;
        if (accept) begin
            sticky_carry_d = sticky_carry_d || in_carry;
            sticky_ovf_d   = sticky_ovf_d || in_ovf;
            flag_err_d     = flag_err_d || (in_zero != (in_result == '0));
            if (result_base != CntMax) begin
                result_count_d = result_base + CntOne;
            end
            if (in_ovf && (ovf_base != CntMax)) begin
                ovf_count_d = ovf_base + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StEmpty;
            main_q         <= '0;
            skid_q         <= '0;
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            flag_err_q     <= 1'b0;
            result_count_q <= '0;
            ovf_count_q    <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StOne;
                        main_q  <= in_entry;
                    end
                end
                StOne: begin
                    if (accept && fire) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        state_q <= StTwo;
                        skid_q  <= in_entry;
                    end else if (fire) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (fire) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
            flag_err_q     <= flag_err_d;
            result_count_q <= result_count_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    assign out_opcode   = main_q.opcode;
    assign out_result   = main_q.result;
    assign out_carry    = main_q.carry;
    assign out_zero     = main_q.zero;
    assign out_ovf      = main_q.ovf;
    assign sticky_carry = sticky_carry_q;
    assign sticky_ovf   = sticky_ovf_q;
    assign flag_err     = flag_err_q;
    assign result_count = result_count_q;
    assign ovf_count    = ovf_count_q;

endmodule
